// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the packet round-robin AXI-Stream arbiter.
// State encoding, default beat limit and a constant clog2.
package axis_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_BEATS_DEF = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_pick.sv
// Rotate-priority encoder: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream master
// among NUM_SRC sources, with a per-packet beat limit.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int MAX_BEATS  = MAX_BEATS_DEF,
  localparam int IW = clog2(NUM_SRC),
  localparam int SW = DATA_WIDTH / 8,
  localparam int CW = clog2(MAX_BEATS + 1)
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*SW-1:0]      S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]         S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]         S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]         S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [SW-1:0]              M_AXIS_TSTRB,
  output logic                       M_AXIS_TVALID,
  output logic                       M_AXIS_TLAST,
  input  logic                       M_AXIS_TREADY,
  input  logic [NUM_SRC-1:0]         src_enable,
  output logic                       grant_valid,
  output logic [IW-1:0]              grant_idx,
  output logic                       forced_last
);

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  arb_state_e    state_q;
  logic          grant_valid_q;
  logic [IW-1:0] grant_idx_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [CW-1:0] beat_cnt_q;
  logic          forced_q;

  logic [NUM_SRC-1:0] req;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               src_last;
  logic               cut;
  logic               beat;

  assign req = S_AXIS_TVALID & src_enable;

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TVALID = 1'b0;
    S_AXIS_TREADY = '0;
    src_last      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_valid_q && grant_idx_q == IW'(i)) begin
        M_AXIS_TDATA     = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        M_AXIS_TSTRB     = S_AXIS_TSTRB[i*SW +: SW];
        M_AXIS_TVALID    = S_AXIS_TVALID[i];
        src_last         = S_AXIS_TLAST[i];
        S_AXIS_TREADY[i] = M_AXIS_TREADY;
      end
    end
  end

  assign cut          = beat_cnt_q == LAST_CNT;
  assign M_AXIS_TLAST = grant_valid_q & (src_last | cut);
  assign beat         = M_AXIS_TVALID & M_AXIS_TREADY;

  // Pointer moves one past the source that just finished a packet
  assign rr_ptr_d = (grant_idx_q == IW'(NUM_SRC - 1)) ? '0 : grant_idx_q + 1'b1;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      forced_q      <= 1'b0;
    end else begin
      forced_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_idx_q   <= pick_idx;
            grant_valid_q <= 1'b1;
            state_q       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (beat) begin
            if (M_AXIS_TLAST) begin
              beat_cnt_q    <= '0;
              grant_valid_q <= 1'b0;
              rr_ptr_q      <= rr_ptr_d;
              forced_q      <= ~src_last;
              state_q       <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign forced_last = forced_q;

endmodule
